if_fetch_unit: RTL

//   Instruction-fetch stage of the OpenMIPS32 5-stage pipeline: owns the PC, drives the

---
 rtl/if_fetch_unit_pkg.sv | 34 +++
 rtl/if_fetch_unit_if.sv | 29 ++
 rtl/if_fetch_unit_if_id_reg.sv | 40 ++++
 rtl/if_fetch_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants and payload types for the OpenMIPS32 fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned STALL_W = 6;

  // Stall vector bit indices consumed by the fetch stage
  localparam int unsigned IF_STALL_PC = 0;
  localparam int unsigned IF_STALL_IF = 1;
  localparam int unsigned IF_STALL_ID = 2;

  typedef logic [ADDR_W-1:0]  inst_addr_t;
  typedef logic [INST_W-1:0]  inst_t;
  typedef logic [STALL_W-1:0] stall_t;

  localparam inst_addr_t DEFAULT_RESET_PC = ADDR_W'(32'h0);
  localparam inst_t      ZERO_WORD        = '0;
  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;

  // IF/ID pipeline payload
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       adel;
  } if_id_t;

  // True when a fetch address is word aligned
  function automatic logic word_aligned(input inst_addr_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Control, ROM and ID-side signal bundle of the fetch stage.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  stall_t     stall_i;
  logic       flush_i;
  inst_addr_t new_pc_i;
  logic       branch_flag_i;
  inst_addr_t branch_target_i;
  logic       rom_ce_o;
  inst_addr_t rom_addr_o;
  inst_t      rom_inst_i;
  inst_addr_t id_pc_o;
  inst_t      id_inst_o;
  logic       id_adel_o;

  // Fetch unit side
  modport master (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
  );

  // Surrounding pipeline / ROM side
  modport slave (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
  );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush and IF-only stall insert a bubble, IF+ID stall holds.
module if_id_reg
  import if_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  logic   stall_if_i,
  input  logic   stall_id_i,
  input  if_id_t fetch_i,
  output if_id_t id_o
);

  if_id_t id_q;
  if_id_t id_d;

  // Next IF/ID contents by flush > bubble > hold > load priority
  always_comb begin
    id_d = id_q;
    if (flush_i) begin
      id_d = '0;
    end else if (stall_if_i && !stall_id_i) begin
      id_d = '0;
    end else if (!stall_if_i) begin
      id_d = fetch_i;
    end
  end

  // IF/ID state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/if_fetch_unit.sv
// OpenMIPS32 instruction fetch: PC, ROM enable/address and IF/ID register.
// Optional IF_ALIGN_CHECK_EN: misaligned PC loads raise AdEL instead of being forced aligned.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter inst_addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input logic           clk,
  input logic           rst,
  if_fetch_unit_if.master bus
);

  inst_addr_t pc_q, pc_d;
  inst_addr_t target_c;
  logic       run_q;
  logic       ce_q, ce_d;
  logic       adel_q, adel_d;
  if_id_t     fetch_c;
  if_id_t     id_c;
  logic       unused_stall_c;

  assign unused_stall_c = ^bus.stall_i[STALL_W-1:IF_STALL_ID+1];

  // Redirect address: exception target beats branch target
  always_comb begin
    target_c = bus.flush_i ? bus.new_pc_i : bus.branch_target_i;
`ifndef IF_ALIGN_CHECK_EN
    target_c[1:0] = 2'b00;
`endif
  end

  // Next PC: flush > PC stall > taken branch > sequential; frozen until fetching starts
  always_comb begin
    pc_d = pc_q;
    if (run_q) begin
      if (bus.flush_i) begin
        pc_d = target_c;
      end else if (!bus.stall_i[IF_STALL_PC]) begin
        pc_d = bus.branch_flag_i ? target_c : pc_q + ADDR_W'(4);
      end
    end
  end

  // Chip enable / address-error flag for the fetch at pc_d
  always_comb begin
`ifdef IF_ALIGN_CHECK_EN
    ce_d   = word_aligned(pc_d) ? CHIP_ENABLE : CHIP_DISABLE;
    adel_d = !word_aligned(pc_d);
`else
    ce_d   = CHIP_ENABLE;
    adel_d = 1'b0;
`endif
  end

  // PC and fetch-enable state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      ce_q   <= CHIP_DISABLE;
      adel_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      run_q  <= 1'b1;
      ce_q   <= ce_d;
      adel_q <= adel_d;
    end
  end

  // Word offered to IF/ID: ROM data when enabled, AdEL marker on a bad address, else zeros
  always_comb begin
    fetch_c = '0;
    if (ce_q) begin
      fetch_c.pc   = pc_q;
      fetch_c.inst = bus.rom_inst_i;
    end else if (adel_q) begin
      fetch_c.pc   = pc_q;
      fetch_c.inst = ZERO_WORD;
      fetch_c.adel = 1'b1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush_i),
    .stall_if_i (bus.stall_i[IF_STALL_IF]),
    .stall_id_i (bus.stall_i[IF_STALL_ID]),
    .fetch_i    (fetch_c),
    .id_o       (id_c)
  );

  assign bus.rom_ce_o   = ce_q;
  assign bus.rom_addr_o = pc_q;
  assign bus.id_pc_o    = id_c.pc;
  assign bus.id_inst_o  = id_c.inst;
  assign bus.id_adel_o  = id_c.adel;

endmodule
